store_bus_checker: RTL and testbench

//   Synthesizable end-of-run checker on the core's data-memory store bus
//   (memwrite/dataadr/writedata out of top). Consumes every store and decides

---
 rtl/store_bus_checker.sv | 191 +++++++++++++++++++
 tb/tb_store_bus_checker.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/store_bus_checker.sv
// -----------------------------------------------------------------------------
// store_bus_checker
//
// End-of-run checker that watches the core's data-memory store bus and decides
// in hardware whether the program finished correctly. Because the verdict is
// produced by logic rather than by a simulator, the same check works on FPGA.
//
// The program is expected to write only to SCRATCH_ADDR while it runs, and to
// finish with a single store of DONE_DATA to DONE_ADDR. Any other store address,
// or the wrong data at DONE_ADDR, is a FAIL. If TIMEOUT_CYC cycles pass without
// a verdict, the checker reports TIMEOUT. Once a verdict is reached it holds
// until reset.
//
// A small first-word-fall-through FIFO keeps a log of recent stores so a host
// (or a debug core) can read back what the program wrote.
//
// Ports
//   clk           in   1   clock, rising edge
//   reset         in   1   asynchronous, active-low; 0 clears all state
//   memwrite      in   1   store strobe from the core
//   dataadr       in   32  store address
//   writedata     in   32  store data
//   log_rd        in   1   pop one log entry (ignored when log is empty)
//   done          out  1   a verdict has been reached
//   pass          out  1   program ended with the correct store
//   fail          out  1   wrong data at DONE_ADDR or store to illegal address
//   timeout       out  1   TIMEOUT_CYC cycles elapsed with no verdict
//   write_count   out  16  stores accepted while running, saturating
//   log_valid     out  1   log FIFO holds at least one entry
//   log_addr      out  32  address of the oldest logged store (0 when empty)
//   log_data      out  32  data of the oldest logged store (0 when empty)
//   log_overflow  out  1   sticky: a store was dropped because the log was full
// -----------------------------------------------------------------------------
module store_bus_checker #(
  parameter logic [31:0] DONE_ADDR    = 32'd84,
  parameter logic [31:0] DONE_DATA    = 32'd7,
  parameter logic [31:0] SCRATCH_ADDR = 32'd80,
  parameter int          TIMEOUT_CYC  = 1000,
  parameter int          LOG_DEPTH    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  input  logic        log_rd,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [15:0] write_count,
  output logic        log_valid,
  output logic [31:0] log_addr,
  output logic [31:0] log_data,
  output logic        log_overflow
);

  localparam int PTR_W = $clog2(LOG_DEPTH);
  localparam int CYC_W = $clog2(TIMEOUT_CYC);

  localparam logic [CYC_W-1:0] CYC_LAST   = CYC_W'(TIMEOUT_CYC - 1);
  localparam logic [PTR_W:0]   FIFO_FULL  = (PTR_W + 1)'(LOG_DEPTH);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    PASS    = 2'd1,
    FAIL    = 2'd2,
    TIMEOUT = 2'd3
  } state_t;

  state_t           state;
  logic [CYC_W-1:0] cyc_cnt;

  // Store decode. A store is only "accepted" while running; in terminal
  // states the bus is ignored completely.
  logic accept;
  logic hit_done;
  logic hit_scratch;
  logic store_good_end;
  logic store_bad;

  assign accept         = (state == RUN) && memwrite;
  assign hit_done       = (dataadr == DONE_ADDR);
  assign hit_scratch    = (dataadr == SCRATCH_ADDR);
  assign store_good_end = hit_done && (writedata == DONE_DATA);
  assign store_bad      = (hit_done && (writedata != DONE_DATA)) ||
                          (!hit_done && !hit_scratch);

  // Verdict FSM with registered one-hot outputs.
  // The cycle counter saturates at its last value: if a scratch store lands
  // on the final cycle (the store wins over the timeout), the very next
  // store-free cycle still times out instead of the counter running past the
  // compare value and wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= RUN;
      cyc_cnt <= '0;
      done    <= 1'b0;
      pass    <= 1'b0;
      fail    <= 1'b0;
      timeout <= 1'b0;
    end else if (state == RUN) begin
      if (cyc_cnt != CYC_LAST) begin
        cyc_cnt <= cyc_cnt + 1'b1;
      end
      if (memwrite) begin
        if (store_good_end) begin
          state <= PASS;
          done  <= 1'b1;
          pass  <= 1'b1;
        end else if (store_bad) begin
          state <= FAIL;
          done  <= 1'b1;
          fail  <= 1'b1;
        end
      end else if (cyc_cnt == CYC_LAST) begin
        state   <= TIMEOUT;
        done    <= 1'b1;
        timeout <= 1'b1;
      end
    end
  end

  // Accepted-store counter, including the store that decides the verdict.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_count <= '0;
    end else if (accept && (write_count != 16'hFFFF)) begin
      write_count <= write_count + 16'd1;
    end
  end

  // Store log FIFO.
  // A full log still accepts a store when a pop happens in the same cycle,
  // since the pop frees the slot the push needs. Only a push into a full log
  // with no pop is dropped, and that sets the sticky overflow flag.
  logic [31:0]      addr_mem [LOG_DEPTH];
  logic [31:0]      data_mem [LOG_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   fill;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;

  assign log_valid = (fill != '0);
  assign full      = (fill == FIFO_FULL);
  assign pop       = log_rd && log_valid;
  assign push      = accept && (!full || pop);
  assign drop      = accept && full && !pop;

  // Pointer and occupancy bookkeeping. Pointers wrap naturally because the
  // depth is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fill         <= '0;
      log_overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        fill <= fill + 1'b1;
      end else if (pop && !push) begin
        fill <= fill - 1'b1;
      end
      if (drop) begin
        log_overflow <= 1'b1;
      end
    end
  end

  // Log storage has no reset so it can map onto RAM; stale contents are
  // never visible because the head output is masked while the log is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= dataadr;
      data_mem[wr_ptr] <= writedata;
    end
  end

  assign log_addr = log_valid ? addr_mem[rd_ptr] : 32'd0;
  assign log_data = log_valid ? data_mem[rd_ptr] : 32'd0;

endmodule

// File: tb/tb_store_bus_checker.sv
// -----------------------------------------------------------------------------
// tb_store_bus_checker
//
// Self-checking bench for store_bus_checker. A behavioural model tracks the
// verdict, the accepted-store count, the store log (as a queue) and the
// overflow flag, and every output is compared against it after each clock.
// Directed scenarios cover the normal ending, both failure kinds, the timeout
// boundary, log overflow and asynchronous reset; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_store_bus_checker;

  localparam int TIMEOUT_CYC = 1000;
  localparam int LOG_DEPTH   = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = '0;
  logic [31:0] writedata = '0;
  logic        log_rd = 1'b0;
  logic        done, pass, fail, timeout;
  logic [15:0] write_count;
  logic        log_valid;
  logic [31:0] log_addr, log_data;
  logic        log_overflow;

  store_bus_checker #(
    .DONE_ADDR   (32'd84),
    .DONE_DATA   (32'd7),
    .SCRATCH_ADDR(32'd80),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .LOG_DEPTH   (LOG_DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .memwrite    (memwrite),
    .dataadr     (dataadr),
    .writedata   (writedata),
    .log_rd      (log_rd),
    .done        (done),
    .pass        (pass),
    .fail        (fail),
    .timeout     (timeout),
    .write_count (write_count),
    .log_valid   (log_valid),
    .log_addr    (log_addr),
    .log_data    (log_data),
    .log_overflow(log_overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: verdict 0=running 1=pass 2=fail 3=timeout.
  int          m_verdict;
  int          m_runs;
  int          m_count;
  bit          m_ovf;
  logic [63:0] m_log[$];

  task automatic modelReset();
    m_verdict = 0;
    m_runs    = 0;
    m_count   = 0;
    m_ovf     = 1'b0;
    m_log.delete();
  endtask

  // Predicts the effect of one rising edge given the inputs present at it.
  task automatic modelStep(input logic mw, input logic [31:0] a,
                           input logic [31:0] d, input logic rd);
    bit pop_ok;
    pop_ok = rd && (m_log.size() > 0);
    if (pop_ok) void'(m_log.pop_front());
    if (m_verdict == 0) begin
      m_runs++;
      if (mw) begin
        if (m_count < 65535) m_count++;
        if (m_log.size() >= LOG_DEPTH) m_ovf = 1'b1;
        else m_log.push_back({a, d});
        if (a == 32'd84) m_verdict = (d == 32'd7) ? 1 : 2;
        else if (a != 32'd80) m_verdict = 2;
      end else if (m_runs >= TIMEOUT_CYC) begin
        m_verdict = 3;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string where);
    logic [31:0] ea, ed;
    ea = (m_log.size() > 0) ? m_log[0][63:32] : 32'd0;
    ed = (m_log.size() > 0) ? m_log[0][31:0]  : 32'd0;
    chk({where, ".done"},     32'(done),         32'(m_verdict != 0));
    chk({where, ".pass"},     32'(pass),         32'(m_verdict == 1));
    chk({where, ".fail"},     32'(fail),         32'(m_verdict == 2));
    chk({where, ".timeout"},  32'(timeout),      32'(m_verdict == 3));
    chk({where, ".count"},    32'(write_count),  32'(m_count));
    chk({where, ".valid"},    32'(log_valid),    32'(m_log.size() > 0));
    chk({where, ".laddr"},    log_addr,          ea);
    chk({where, ".ldata"},    log_data,          ed);
    chk({where, ".ovf"},      32'(log_overflow), 32'(m_ovf));
  endtask

  // One clock: drive inputs, predict, sample #1 after the edge, then check.
  task automatic applyStimulus(input string where, input logic mw,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic rd);
    memwrite  = mw;
    dataadr   = a;
    writedata = d;
    log_rd    = rd;
    modelStep(mw, a, d, rd);
    @(posedge clk);
    #1;
    memwrite = 1'b0;
    log_rd   = 1'b0;
    checkOutput(where);
  endtask

  task automatic doReset(input string where);
    reset = 1'b0;
    memwrite = 1'b0;
    log_rd = 1'b0;
    modelReset();
    #7;
    checkOutput({where, ".rst"});
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // 1: normal ending and log readback
    doReset("t1");
    applyStimulus("t1", 1, 32'd80, 32'd5, 0);
    applyStimulus("t1", 1, 32'd80, 32'd3, 0);
    chk("t1.pre_pass", 32'(pass), 32'd0);
    applyStimulus("t1", 1, 32'd84, 32'd7, 0);
    chk("t1.pass_const", 32'(pass), 32'd1);
    chk("t1.count_const", 32'(write_count), 32'd3);
    chk("t1.head_const", log_data, 32'd5);
    for (int i = 0; i < 4; i++) applyStimulus("t1.pop", 0, 0, 0, 1);
    chk("t1.empty_const", 32'(log_valid), 32'd0);

    // 2: wrong data at the done address, then a late store is ignored
    doReset("t2");
    applyStimulus("t2", 1, 32'd84, 32'd6, 0);
    applyStimulus("t2", 1, 32'd84, 32'd7, 0);
    chk("t2.fail_const", 32'(fail), 32'd1);
    chk("t2.count_const", 32'(write_count), 32'd1);

    // 3: illegal address
    doReset("t3");
    applyStimulus("t3", 0, 0, 0, 0);
    applyStimulus("t3", 1, 32'd88, 32'd7, 0);
    chk("t3.fail_const", 32'(fail), 32'd1);

    // 4a: pure timeout
    doReset("t4a");
    for (int i = 0; i < TIMEOUT_CYC - 1; i++) applyStimulus("t4a", 0, 0, 0, 0);
    chk("t4a.not_yet", 32'(timeout), 32'd0);
    applyStimulus("t4a", 0, 0, 0, 0);
    chk("t4a.timeout_const", 32'(timeout), 32'd1);
    for (int i = 0; i < 3; i++) applyStimulus("t4a.hold", 1, 32'd84, 32'd7, 0);

    // 4b: deciding store on the last cycle beats the timeout
    doReset("t4b");
    for (int i = 0; i < TIMEOUT_CYC - 1; i++) applyStimulus("t4b", 0, 0, 0, 0);
    applyStimulus("t4b", 1, 32'd84, 32'd7, 0);
    chk("t4b.pass_const", 32'(pass), 32'd1);
    chk("t4b.timeout_const", 32'(timeout), 32'd0);

    // 4c: scratch store on the last cycle, timeout on the next idle cycle
    doReset("t4c");
    for (int i = 0; i < TIMEOUT_CYC - 1; i++) applyStimulus("t4c", 0, 0, 0, 0);
    applyStimulus("t4c", 1, 32'd80, 32'd1, 0);
    chk("t4c.running", 32'(done), 32'd0);
    applyStimulus("t4c", 0, 0, 0, 0);

    // 5a: overflow after nine stores without pops
    doReset("t5a");
    for (int i = 0; i < 9; i++) applyStimulus("t5a", 1, 32'd80, 32'(100 + i), 0);
    chk("t5a.ovf_const", 32'(log_overflow), 32'd1);
    for (int i = 0; i < LOG_DEPTH + 1; i++) applyStimulus("t5a.pop", 0, 0, 0, 1);

    // 5b: push and pop together on a full log
    doReset("t5b");
    for (int i = 0; i < 8; i++) applyStimulus("t5b", 1, 32'd80, 32'(200 + i), 0);
    applyStimulus("t5b", 1, 32'd80, 32'd208, 1);
    chk("t5b.ovf_const", 32'(log_overflow), 32'd0);
    for (int i = 0; i < LOG_DEPTH + 1; i++) applyStimulus("t5b.pop", 0, 0, 0, 1);

    // 6: asynchronous reset mid-run
    doReset("t6");
    for (int i = 0; i < 4; i++) applyStimulus("t6", 1, 32'd80, 32'(i), 0);
    #3;
    reset = 1'b0;
    #1;
    chk("t6.count_zero", 32'(write_count), 32'd0);
    chk("t6.valid_zero", 32'(log_valid), 32'd0);
    chk("t6.laddr_zero", log_addr, 32'd0);
    chk("t6.done_zero", 32'(done), 32'd0);
    modelReset();
    checkOutput("t6.async");

    // Randomized runs
    for (int r = 0; r < 10; r++) begin
      doReset("rnd");
      for (int i = 0; i < 60; i++) begin
        int          sel;
        logic        mw;
        logic [31:0] a, d;
        mw  = ($urandom_range(0, 2) != 0);
        sel = $urandom_range(0, 99);
        if (sel < 93)      a = 32'd80;
        else if (sel < 97) a = 32'd84;
        else               a = $urandom_range(0, 255);
        d = (a == 32'd84 && $urandom_range(0, 1) == 1) ? 32'd7 : $urandom;
        applyStimulus("rnd", mw, a, d, ($urandom_range(0, 3) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
